nf10_axis_rr_input_arbiter: RTL and testbench
=============================================

// Module: nf10_axis_rr_input_arbiter
// PURPOSE
//  Packet-granular round-robin arbiter that merges C_NUM_PORTS AXI4-Stream slaves (10G MAC / DMA ports)
//  into one master feeding the output-port lookup. A grant is held for a whole packet, up to and
//  including the tlast beat. A one-stage output register gives full-throughput pipelining.
//  One clock domain (axi_aclk). Reset is synchronous and active-high (axi_reset).
// PARAMETERS
//  C_NUM_PORTS          4    number of slave ports; legal range 2..8
//  C_AXIS_DATA_WIDTH    256  tdata width; tstrb width = C_AXIS_DATA_WIDTH/8
//  C_AXIS_TUSER_WIDTH   128  tuser width; tuser passes through unmodified
// PORTS
//  axi_aclk       in   1       clock
//  axi_reset      in   1       synchronous, active-high reset
//  s_axis_tdata   in   N*DW    flattened; port i occupies [i*DW +: DW]
//  s_axis_tstrb   in   N*DW/8  flattened per port
//  s_axis_tuser   in   N*UW    flattened per port
//  s_axis_tvalid  in   N       per-port valid
//  s_axis_tready  out  N       per-port ready
//  s_axis_tlast   in   N       per-port end of packet
//  m_axis_tdata   out  DW      merged stream (tstrb/tuser/tvalid/tready/tlast likewise)
//  m_axis_tstrb   out  DW/8
//  m_axis_tuser   out  UW
//  m_axis_tvalid  out  1
//  m_axis_tready  in   1
//  m_axis_tlast   out  1
//  grant_onehot   out  N       current grant; all zero in IDLE (debug/stats)
// BEHAVIOUR
//  Reset: state=IDLE, rr_ptr=0, grant=0, all m_axis_* outputs=0, s_axis_tready=0. Applies on the next edge.
//  FSM IDLE:
//   - If any s_axis_tvalid is set, pick the first valid index scanning rr_ptr, rr_ptr+1, ... (mod N).
//   - Register the grant; go to PKT. Nothing is accepted in IDLE (one-cycle gap between packets).
//  FSM PKT (grant=g):
//   - pipe_ready = ~m_axis_tvalid | m_axis_tready.
//   - s_axis_tready[g] = pipe_ready; every other port's tready = 0.
//   - Beat on port g accepted (tvalid & tready) with tlast: go to IDLE; rr_ptr = (g==N-1) ? 0 : g+1.
//  Output register:
//   - Accepted beat: load tdata/tstrb/tuser/tlast; set m_axis_tvalid.
//   - Else, if m_axis_tready: clear m_axis_tvalid.
//   - Input-to-output latency is 1 cycle; first beat leaves 2 cycles after IDLE sees tvalid.
//  Handshake rules:
//   - While m_axis_tvalid=1 and m_axis_tready=0, all m_axis_* outputs hold stable.
//   - s_axis_tready never depends combinationally on s_axis_tvalid.
//  Boundary conditions:
//   - Granted port drops tvalid mid-packet: the grant holds; no other port is served until g's tlast.
//   - Single-beat packet (tlast on first beat): legal; back to IDLE after 1 beat.
//   - Only one requester: it is re-granted after each 1-cycle IDLE gap.
//   - tlast accepted while output stalled: impossible, because tready is gated by pipe_ready.
//   - Reset mid-packet: output beat discarded; the partial upstream packet is the upstream's problem.
//     The arbiter does not resync to a packet boundary.
// STRUCTURE
//  Package nf10_axis_arb_pkg:
//   - state encoding (IDLE, PKT)
//   - PTR_W = clog2(C_NUM_PORTS)
//  Sub-module nf10_rr_pick: combinational rotate-priority encoder.
//   - inputs: req[N], ptr[PTR_W]
//   - outputs: gnt_onehot[N], gnt_idx[PTR_W], any
//  Top level holds the FSM, rr_ptr, grant register, mux and output register.
// TESTING
//  1 Port0 sends 3-beat packet D0..D2, m_tready=1 -> m beats at cycles t+2..t+4; tlast only with D2.
//  2 All 4 ports send a 2-beat packet each, continuously -> output order 0,1,2,3,0; 1 idle cycle between.
//  3 m_tready pattern 1,0,1,0 during a 4-beat packet -> 4 beats out, none dropped or duplicated; data stable
//    while stalled.
//  4 Port2 granted, drops tvalid for 3 cycles mid-packet while port1 is valid -> port1 tready stays 0 until
//    port2 tlast accepted.
//  5 Only port3 then port0 request -> after port3 tlast, rr_ptr=0; port0 granted next.
//  6 axi_reset pulsed mid-packet -> next cycle m_axis_tvalid=0, s_axis_tready=0, grant_onehot=0, rr_ptr=0.

Source files
------------

// File: rtl/nf10_axis_rr_input_arbiter_pkg.sv
// nf10_axis_arb_pkg: shared FSM encoding and pointer-width helper for the round-robin input arbiter
package nf10_axis_arb_pkg;
  typedef enum logic {IDLE, PKT} state_t;
  function automatic int ptr_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/nf10_axis_rr_input_arbiter_if.sv
// nf10_axis_rr_input_arbiter_if: bundle of N flattened AXI4-Stream lanes with master/slave views
interface nf10_axis_rr_input_arbiter_if #(parameter int N = 1, parameter int DW = 256, parameter int UW = 128);
  logic [N*DW-1:0] tdata;
  logic [N*DW/8-1:0] tstrb;
  logic [N*UW-1:0] tuser;
  logic [N-1:0] tvalid;
  logic [N-1:0] tready;
  logic [N-1:0] tlast;
  modport master(output tdata, tstrb, tuser, tvalid, tlast, input tready);
  modport slave(input tdata, tstrb, tuser, tvalid, tlast, output tready);
endinterface

// File: rtl/nf10_axis_rr_input_arbiter_pick.sv
// nf10_rr_pick: rotate-priority encoder picking the first request at or after ptr
module nf10_rr_pick
  import nf10_axis_arb_pkg::*;
#(
  parameter int N = 4,
  parameter int PW = ptr_w(N)
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  gnt_onehot,
  output logic [PW-1:0] gnt_idx,
  output logic          any
);
  always_comb begin
    gnt_idx = '0;
    any = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[(int'(ptr) + i) % N]) begin
        gnt_idx = PW'((int'(ptr) + i) % N);
        any = 1'b1;
      end
    end
    gnt_onehot = any ? N'(1) << gnt_idx : '0;
  end
endmodule

// File: rtl/nf10_axis_rr_input_arbiter.sv
// nf10_axis_rr_input_arbiter: packet-granular round-robin merge of N AXI4-Stream slaves into one registered master
module nf10_axis_rr_input_arbiter
  import nf10_axis_arb_pkg::*;
#(
  parameter int C_NUM_PORTS = 4,
  parameter int C_AXIS_DATA_WIDTH = 256,
  parameter int C_AXIS_TUSER_WIDTH = 128
) (
  input  logic                         axi_aclk,
  input  logic                         axi_reset,
  nf10_axis_rr_input_arbiter_if.slave  s_axis,
  nf10_axis_rr_input_arbiter_if.master m_axis,
  output logic [C_NUM_PORTS-1:0]       grant_onehot
);
  localparam int N = C_NUM_PORTS;
  localparam int DW = C_AXIS_DATA_WIDTH;
  localparam int SW = DW / 8;
  localparam int UW = C_AXIS_TUSER_WIDTH;
  localparam int PW = ptr_w(N);
  state_t state;
  logic [PW-1:0] rr_ptr, gnt, pick_idx;
  logic [N-1:0] pick_oh;
  logic pick_any, pipe_ready, accept, sel_last;
  nf10_rr_pick #(.N(N), .PW(PW)) u_pick (
    .req(s_axis.tvalid),
    .ptr(rr_ptr),
    .gnt_onehot(pick_oh),
    .gnt_idx(pick_idx),
    .any(pick_any)
  );
  assign pipe_ready = ~m_axis.tvalid[0] | m_axis.tready[0];
  assign s_axis.tready = pipe_ready ? grant_onehot : '0;
  assign accept = |(s_axis.tvalid & s_axis.tready);
  assign sel_last = s_axis.tlast[gnt];
  always_ff @(posedge axi_aclk) begin
    if (axi_reset) begin
      state <= IDLE;
      rr_ptr <= '0;
      gnt <= '0;
      grant_onehot <= '0;
      m_axis.tdata <= '0;
      m_axis.tstrb <= '0;
      m_axis.tuser <= '0;
      m_axis.tvalid <= '0;
      m_axis.tlast <= '0;
    end else begin
      m_axis.tvalid[0] <= accept | (m_axis.tvalid[0] & ~m_axis.tready[0]);
      if (accept) begin
        m_axis.tdata <= s_axis.tdata[int'(gnt)*DW +: DW];
        m_axis.tstrb <= s_axis.tstrb[int'(gnt)*SW +: SW];
        m_axis.tuser <= s_axis.tuser[int'(gnt)*UW +: UW];
        m_axis.tlast[0] <= sel_last;
      end
      if (state == IDLE && pick_any) begin
        state <= PKT;
        gnt <= pick_idx;
        grant_onehot <= pick_oh;
      end
      if (state == PKT && accept && sel_last) begin
        state <= IDLE;
        grant_onehot <= '0;
        rr_ptr <= (gnt == PW'(N - 1)) ? '0 : gnt + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_nf10_axis_rr_input_arbiter.sv
// tb_nf10_axis_rr_input_arbiter: randomized self-checking bench against a packet-level round-robin model
module tb_nf10_axis_rr_input_arbiter;
  localparam int N = 4;
  localparam int DW = 32;
  localparam int SW = DW / 8;
  localparam int UW = 16;
  typedef struct packed {
    logic [DW-1:0] d;
    logic [SW-1:0] s;
    logic [UW-1:0] u;
    logic l;
  } beat_t;
  logic clk = 1'b0;
  logic rst;
  logic [N-1:0] grant;
  always #5 clk = ~clk;
  nf10_axis_rr_input_arbiter_if #(.N(N), .DW(DW), .UW(UW)) s_if ();
  nf10_axis_rr_input_arbiter_if #(.N(1), .DW(DW), .UW(UW)) m_if ();
  nf10_axis_rr_input_arbiter #(
    .C_NUM_PORTS(N),
    .C_AXIS_DATA_WIDTH(DW),
    .C_AXIS_TUSER_WIDTH(UW)
  ) dut (
    .axi_aclk(clk),
    .axi_reset(rst),
    .s_axis(s_if),
    .m_axis(m_if),
    .grant_onehot(grant)
  );
  beat_t src[N][$];
  beat_t mq[N][$];
  beat_t exp_q[$];
  bit sop[N];
  int gap[N];
  int model_ptr, checks, failures, cyc, rdy_mode, p1_hits;
  bit gap_rand, prev_stall, watch;
  beat_t prev_m;
  int fc[$];
  bit fl[$];
  logic [N-1:0] acc;
  task automatic load_pkt(input int p, input int len);
    beat_t x;
    for (int b = 0; b < len; b++) begin
      x.d = DW'($urandom);
      x.s = SW'($urandom);
      x.u = UW'($urandom);
      x.l = (b == len - 1);
      src[p].push_back(x);
      mq[p].push_back(x);
    end
  endtask
  task automatic model_run();
    int p;
    bit done;
    beat_t x;
    done = 1'b0;
    while (!done) begin
      p = -1;
      for (int k = 0; k < N; k++)
        if (p < 0 && mq[(model_ptr + k) % N].size() > 0) p = (model_ptr + k) % N;
      if (p < 0) done = 1'b1;
      else begin
        do begin
          x = mq[p].pop_front();
          exp_q.push_back(x);
        end while (!x.l);
        model_ptr = (p + 1) % N;
      end
    end
  endtask
  task automatic drive();
    beat_t x;
    for (int i = 0; i < N; i++) begin
      x = '0;
      if (src[i].size() > 0) x = src[i][0];
      s_if.tdata[i*DW +: DW] = x.d;
      s_if.tstrb[i*SW +: SW] = x.s;
      s_if.tuser[i*UW +: UW] = x.u;
      s_if.tlast[i] = x.l;
      if (src[i].size() == 0) s_if.tvalid[i] = 1'b0;
      else if (sop[i]) s_if.tvalid[i] = 1'b1;
      else if (gap[i] > 0) begin
        s_if.tvalid[i] = 1'b0;
        gap[i]--;
      end else s_if.tvalid[i] = gap_rand ? ($urandom_range(0, 2) != 0) : 1'b1;
    end
    m_if.tready[0] = (rdy_mode == 0) ? 1'b1 : (rdy_mode == 1) ? 1'($urandom_range(0, 1)) : (cyc % 2 == 0);
  endtask
  task automatic step();
    beat_t cur, e, x;
    @(negedge clk);
    acc = s_if.tvalid & s_if.tready;
    checks++;
    if (!$onehot0(s_if.tready)) begin
      failures++;
      $display("FAIL tready_onehot got=%b want at most one bit", s_if.tready);
    end
    if (m_if.tvalid[0] && !m_if.tready[0]) begin
      checks++;
      if (s_if.tready !== '0) begin
        failures++;
        $display("FAIL tready_while_stalled got=%b want=0", s_if.tready);
      end
    end
    cur.d = m_if.tdata;
    cur.s = m_if.tstrb;
    cur.u = m_if.tuser;
    cur.l = m_if.tlast[0];
    if (prev_stall) begin
      checks++;
      if (cur !== prev_m || m_if.tvalid[0] !== 1'b1) begin
        failures++;
        $display("FAIL stall_hold got=%h/v%b want=%h/v1", cur, m_if.tvalid, prev_m);
      end
    end
    prev_stall = m_if.tvalid[0] & ~m_if.tready[0];
    prev_m = cur;
    if (watch && s_if.tready[1]) p1_hits++;
    if (watch && acc[2] && s_if.tlast[2]) watch = 1'b0;
    if (m_if.tvalid[0] && m_if.tready[0]) begin
      fc.push_back(cyc);
      fl.push_back(cur.l);
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_beat got=%h want=none", cur);
      end else begin
        e = exp_q.pop_front();
        if (cur !== e) begin
          failures++;
          $display("FAIL out_beat got=%h want=%h", cur, e);
        end
      end
    end
    @(posedge clk);
    cyc++;
    #1;
    for (int i = 0; i < N; i++)
      if (acc[i]) begin
        x = src[i].pop_front();
        sop[i] = x.l;
      end
    drive();
  endtask
  function automatic bit busy();
    for (int i = 0; i < N; i++) if (src[i].size() > 0) return 1'b1;
    return 1'b0;
  endfunction
  task automatic drain(input int max, input string name);
    int n;
    n = 0;
    while ((exp_q.size() > 0 || busy()) && n < max) begin
      step();
      n++;
    end
    checks++;
    if (n >= max) begin
      failures++;
      $display("FAIL %s_timeout got=%0d beats left want=0", name, exp_q.size());
    end
  endtask
  task automatic wait_grant(input logic [N-1:0] want, input string name);
    int n;
    n = 0;
    while (grant == '0 && n < 20) begin
      step();
      n++;
    end
    checks++;
    if (grant !== want) begin
      failures++;
      $display("FAIL %s_grant got=%b want=%b", name, grant, want);
    end
  endtask
  task automatic flush();
    for (int i = 0; i < N; i++) begin
      src[i].delete();
      mq[i].delete();
      sop[i] = 1'b1;
      gap[i] = 0;
    end
    exp_q.delete();
    model_ptr = 0;
    prev_stall = 1'b0;
  endtask
  task automatic check_reset_outputs(input string name);
    checks++;
    if (m_if.tvalid !== 1'b0 || s_if.tready !== '0 || grant !== '0 || m_if.tlast !== 1'b0 || m_if.tdata !== '0) begin
      failures++;
      $display("FAIL %s got=v%b rdy%b g%b l%b d%h want=all zero", name, m_if.tvalid, s_if.tready, grant, m_if.tlast, m_if.tdata);
    end
  endtask
  task automatic test_reset();
    rst = 1'b1;
    s_if.tvalid = '0;
    s_if.tdata = '0;
    s_if.tstrb = '0;
    s_if.tuser = '0;
    s_if.tlast = '0;
    m_if.tready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    cyc = 0;
    rdy_mode = 0;
    gap_rand = 1'b0;
    watch = 1'b0;
    flush();
    check_reset_outputs("reset_state");
    drive();
  endtask
  task automatic test_round_robin();
    load_pkt(0, 2);
    load_pkt(0, 2);
    for (int p = 1; p < N; p++) load_pkt(p, 2);
    model_run();
    fc.delete();
    fl.delete();
    drain(200, "rr");
    for (int j = 1; j < fc.size(); j++) begin
      checks++;
      if (fc[j] - fc[j-1] != (fl[j-1] ? 2 : 1)) begin
        failures++;
        $display("FAIL rr_spacing beat%0d got=%0d want=%0d", j, fc[j] - fc[j-1], fl[j-1] ? 2 : 1);
      end
    end
  endtask
  task automatic test_latency();
    int c0;
    load_pkt(0, 3);
    model_run();
    drive();
    c0 = cyc;
    fc.delete();
    fl.delete();
    drain(50, "latency");
    checks++;
    if (fc.size() != 3) begin
      failures++;
      $display("FAIL latency_count got=%0d want=3", fc.size());
    end else
      for (int k = 0; k < 3; k++) begin
        checks++;
        if (fc[k] != c0 + 2 + k || fl[k] != (k == 2)) begin
          failures++;
          $display("FAIL latency_beat%0d got=cyc%0d/l%0b want=cyc%0d/l%0b", k, fc[k] - c0, fl[k], 2 + k, k == 2);
        end
      end
  endtask
  task automatic test_stall();
    rdy_mode = 2;
    load_pkt(3, 4);
    model_run();
    fc.delete();
    fl.delete();
    drain(100, "stall");
    checks++;
    if (fc.size() != 4) begin
      failures++;
      $display("FAIL stall_count got=%0d want=4", fc.size());
    end
    rdy_mode = 0;
  endtask
  task automatic test_hold_grant();
    gap[2] = 3;
    load_pkt(2, 4);
    model_run();
    wait_grant(4'b0100, "hold");
    load_pkt(1, 2);
    model_run();
    p1_hits = 0;
    watch = 1'b1;
    drain(100, "hold");
    checks++;
    if (p1_hits != 0 || watch) begin
      failures++;
      $display("FAIL hold_port1_ready got=%0d cycles/pending%0b want=0/0", p1_hits, watch);
    end
    watch = 1'b0;
  endtask
  task automatic test_ptr_wrap();
    load_pkt(3, 2);
    model_run();
    drain(50, "wrap3");
    for (int p = 0; p < 3; p++) load_pkt(p, 1);
    model_run();
    wait_grant(4'b0001, "wrap");
    drain(50, "wrap");
  endtask
  task automatic test_reset_mid();
    int n;
    load_pkt(1, 6);
    model_run();
    n = 0;
    while (m_if.tvalid !== 1'b1 && n < 20) begin
      step();
      n++;
    end
    step();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    cyc++;
    check_reset_outputs("reset_mid");
    flush();
    drive();
    for (int p = 0; p < N; p++) load_pkt(p, 2);
    model_run();
    wait_grant(4'b0001, "reset_ptr");
    drain(100, "reset_mid");
  endtask
  task automatic test_random();
    gap_rand = 1'b1;
    rdy_mode = 1;
    for (int r = 0; r < 4; r++) begin
      for (int p = 0; p < N; p++) begin
        int np;
        np = $urandom_range(0, 3);
        for (int k = 0; k < np; k++) load_pkt(p, $urandom_range(1, 5));
      end
      model_run();
      drain(3000, "random");
    end
    repeat (4) step();
    checks++;
    if (exp_q.size() != 0 || m_if.tvalid !== 1'b0) begin
      failures++;
      $display("FAIL random_idle got=left%0d/v%b want=0/0", exp_q.size(), m_if.tvalid);
    end
  endtask
  initial begin
    #500000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end
  initial begin
    checks = 0;
    failures = 0;
    test_reset();
    test_round_robin();
    test_latency();
    test_stall();
    test_hold_grant();
    test_ptr_wrap();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
